// File: rtl/bias_writeback_ctrl.sv
// Bias update sequencer: for each entry, reads the old bias, takes one delta and
// writes back bias + sat((LEARNINGRATE*delta)>>>FRAC) to the same BRAM address.
module bias_writeback_ctrl #(
    parameter int                DWIDTH       = 32,
    parameter int                AWIDTH       = 10,
    parameter int                NUM_BIAS     = 16,
    parameter int                BASE_ADDR    = 0,
    parameter int                FRAC         = 16,
    parameter logic [DWIDTH-1:0] LEARNINGRATE = 32'h0000068D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] delta_in,
    input  logic              delta_valid,
    output logic              delta_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [AWIDTH-1:0] bram_addr,
    output logic [DWIDTH-1:0] bram_din,
    input  logic [DWIDTH-1:0] bram_dout,
    output logic              busy,
    output logic              done
);

    localparam int IW = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1;
    localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_BIAS - 1);
    localparam logic [AWIDTH-1:0] BASE     = AWIDTH'(BASE_ADDR);

    localparam logic signed [DWIDTH-1:0]   LR_S = LEARNINGRATE;
    localparam logic signed [DWIDTH-1:0]   SMAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0]   SMIN = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic signed [2*DWIDTH-1:0] PMAX = (2*DWIDTH)'(SMAX);
    localparam logic signed [2*DWIDTH-1:0] PMIN = (2*DWIDTH)'(SMIN);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        GETD,
        CALC,
        WR,
        DONE
    } state_t;

    state_t state, state_nx;

    logic        [IW-1:0]     idx;
    logic signed [DWIDTH-1:0] bias_r;
    logic signed [DWIDTH-1:0] delta_r;
    logic        [DWIDTH-1:0] din_r;

    logic signed [2*DWIDTH-1:0] prod;
    logic signed [2*DWIDTH-1:0] prod_sh;
    logic signed [DWIDTH-1:0]   step;
    logic        [DWIDTH:0]     sum;
    logic        [DWIDTH-1:0]   new_bias;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RD;
            RD:      state_nx = RDW;
            RDW:     state_nx = GETD;
            GETD:    if (delta_valid) state_nx = CALC;
            CALC:    state_nx = WR;
            WR:      state_nx = (idx == LAST_IDX) ? DONE : RD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scaled step saturated to DWIDTH first, then the bias add saturates again.
    always_comb begin
        prod    = (2*DWIDTH)'(LR_S) * (2*DWIDTH)'(delta_r);
        prod_sh = prod >>> FRAC;
        if (prod_sh > PMAX) begin
            step = SMAX;
        end else if (prod_sh < PMIN) begin
            step = SMIN;
        end else begin
            step = prod_sh[DWIDTH-1:0];
        end
        sum = {bias_r[DWIDTH-1], bias_r} + {step[DWIDTH-1], step};
        if (sum[DWIDTH] != sum[DWIDTH-1]) begin
            new_bias = sum[DWIDTH] ? SMIN : SMAX;
        end else begin
            new_bias = sum[DWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            bias_r  <= '0;
            delta_r <= '0;
            din_r   <= '0;
        end else begin
            case (state)
                IDLE:    if (start) idx <= '0;
                RDW:     bias_r <= bram_dout;
                GETD:    if (delta_valid) delta_r <= delta_in;
                CALC:    din_r <= new_bias;
                WR:      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are forced to reset values while rst is high so a WR-cycle write is dropped.
    always_comb begin
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = BASE;
        bram_din    = '0;
        delta_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        if (!rst) begin
            bram_en     = (state == RD) || (state == WR);
            bram_we     = (state == WR);
            bram_addr   = BASE + AWIDTH'(idx);
            bram_din    = din_r;
            delta_ready = (state == GETD);
            busy        = (state != IDLE);
            done        = (state == DONE);
        end
    end

endmodule

// File: tb/tb_bias_writeback_ctrl.sv
// Scoreboard bench for bias_writeback_ctrl: expected BRAM reads/writes are queued by
// the stimulus process and checked by a monitor on the falling edge.
module tb_bias_writeback_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int NB   = 16;
    localparam int BASE = 32;

    localparam logic [DW-1:0] BIAS_TAB [NB] = '{
        32'h00020000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000,
        32'h00010000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h7FFFFFF0, 32'h80000010,
        32'h12345678, 32'hFFFF0000, 32'h00100000, 32'hFFFFFFFF};
    localparam logic [DW-1:0] DELTA_TAB [NB] = '{
        32'h00010000, 32'hFFFF0000, 32'h7FFFFFFF, 32'hFFFF0000,
        32'h00000000, 32'h00020000, 32'h00008000, 32'hFFFF8000,
        32'h00000001, 32'hFFFFFFFF, 32'h00010000, 32'hFFFF0000,
        32'h00000000, 32'h00010000, 32'h00100000, 32'h00000000};
    localparam logic [DW-1:0] EXP_TAB [NB] = '{
        32'h0002068D, 32'hFFFFF973, 32'h7FFFFFFF, 32'h80000000,
        32'h00010000, 32'h00000D1A, 32'h00000346, 32'hFFFFFCB9,
        32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
        32'h12345678, 32'hFFFF068D, 32'h001068D0, 32'hFFFFFFFF};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] delta_in;
    logic          delta_valid;
    logic          delta_ready;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    bias_writeback_ctrl #(
        .DWIDTH      (DW),
        .AWIDTH      (AW),
        .NUM_BIAS    (NB),
        .BASE_ADDR   (BASE),
        .FRAC        (16),
        .LEARNINGRATE(32'h0000068D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .delta_in   (delta_in),
        .delta_valid(delta_valid),
        .delta_ready(delta_ready),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .busy       (busy),
        .done       (done)
    );

    logic [DW-1:0]    mem [1024];
    logic             ld_all = 1'b0;
    int               dptr = 0;
    logic [AW-1:0]    rd_q [$];
    logic [AW+DW-1:0] wr_q [$];
    int               vectors = 0;
    int               miscompares = 0;
    int               wr_seen = 0;
    int               done_cnt = 0;

    // BRAM model with one-cycle read latency; delta source steps on each handshake.
    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < NB; i++) mem[BASE+i] <= BIAS_TAB[i];
            dptr <= 0;
        end else begin
            if (bram_en && bram_we) mem[bram_addr] <= bram_din;
            if (bram_en && !bram_we) bram_dout <= mem[bram_addr];
            if (delta_valid && delta_ready) dptr <= dptr + 1;
        end
    end

    assign delta_in = DELTA_TAB[dptr[3:0]];

    always @(negedge clk) begin
        logic [AW-1:0]    ea;
        logic [AW+DW-1:0] ew;
        if (bram_en && !bram_we) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: read addr %0d, none expected", bram_addr);
            end else begin
                ea = rd_q.pop_front();
                if (bram_addr !== ea) begin
                    miscompares++;
                    $display("FAIL rd_addr: got %0d expected %0d", bram_addr, ea);
                end
            end
        end
        if (bram_en && bram_we) begin
            wr_seen++;
            vectors++;
            if (wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: write addr %0d data 0x%08h, none expected", bram_addr, bram_din);
            end else begin
                ew = wr_q.pop_front();
                if ({bram_addr, bram_din} !== ew) begin
                    miscompares++;
                    $display("FAIL wr: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             bram_addr, bram_din, ew[AW+DW-1:DW], ew[DW-1:0]);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load();
        ld_all = 1'b1;
        tick();
        ld_all = 1'b0;
    endtask

    task automatic push_sweep(input int n_rd, input int n_wr);
        for (int i = 0; i < n_rd; i++) rd_q.push_back(AW'(BASE + i));
        for (int i = 0; i < n_wr; i++) wr_q.push_back({AW'(BASE + i), EXP_TAB[i]});
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_en"},    64'(bram_en),     64'd0);
        chk({tag, "_we"},    64'(bram_we),     64'd0);
        chk({tag, "_ready"}, 64'(delta_ready), 64'd0);
        chk({tag, "_busy"},  64'(busy),        64'd0);
        chk({tag, "_done"},  64'(done),        64'd0);
        chk({tag, "_addr"},  64'(bram_addr),   64'(BASE));
        chk({tag, "_din"},   64'(bram_din),    64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (!done && cycles < 300) begin
            tick();
            cycles++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic mem_chk(input string tag, input int n_upd);
        for (int i = 0; i < NB; i++)
            chk(tag, 64'(mem[BASE+i]), 64'((i < n_upd) ? EXP_TAB[i] : BIAS_TAB[i]));
    endtask

    initial begin
        int cycles;
        int n;
        int w0;
        rst = 1'b1;
        start = 1'b0;
        delta_valid = 1'b0;
        repeat (3) tick();
        reset_chk("rst");
        rst = 1'b0;

        // Sweep 1: delta always valid, hand-computed vectors incl. saturation and floor.
        load();
        push_sweep(NB, NB);
        delta_valid = 1'b1;
        pulse_start();
        wait_done(cycles);
        chk("sweep_latency", 64'(cycles), 64'd81);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        mem_chk("mem_sweep1", NB);

        // Sweep 2: stall in GETD for 10 cycles on entry 0.
        load();
        push_sweep(NB, NB);
        delta_valid = 1'b0;
        pulse_start();
        n = 0;
        while (!delta_ready && n < 20) begin
            tick();
            n++;
        end
        chk("getd_reached", 64'(delta_ready), 64'd1);
        w0 = wr_seen;
        repeat (10) begin
            tick();
            chk("hold_ready", 64'(delta_ready), 64'd1);
        end
        chk("hold_no_write", 64'(wr_seen), 64'(w0));
        chk("hold_busy", 64'(busy), 64'd1);
        delta_valid = 1'b1;
        wait_done(cycles);
        tick();
        chk("stall_wr_q_empty", 64'(wr_q.size()), 64'd0);
        mem_chk("mem_sweep2", NB);

        // Sweep 3: ignored mid-sweep start, then reset during WR of entry 5.
        load();
        push_sweep(6, 5);
        pulse_start();
        repeat (11) tick();
        pulse_start();
        repeat (17) tick();
        chk("wr5_we", 64'(bram_we), 64'd1);
        chk("wr5_addr", 64'(bram_addr), 64'(BASE + 5));
        rst = 1'b1;
        #1;
        chk("rst_wr_we", 64'(bram_we), 64'd0);
        chk("rst_wr_en", 64'(bram_en), 64'd0);
        tick();
        reset_chk("midrst");
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("rst_rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("rst_wr_q_empty", 64'(wr_q.size()), 64'd0);
        mem_chk("mem_partial", 5);

        // Sweep 4: restart after reset begins at entry 0.
        load();
        push_sweep(NB, NB);
        pulse_start();
        wait_done(cycles);
        chk("restart_latency", 64'(cycles), 64'd81);
        tick();
        chk("restart_wr_q_empty", 64'(wr_q.size()), 64'd0);
        mem_chk("mem_sweep4", NB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
